// File: rtl/iter_normalizer.sv
// iter_normalizer: multi-cycle CLZ/CTZ unit. Shifts the operand one bit per
// cycle until its leading (mode 0) or trailing (mode 1) bit is set, and reports
// the normalized value plus the number of positions shifted.
module iter_normalizer #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] operand,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [CW-1:0]    count,
   output logic             zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             md;
   logic             test_bit;
   logic             load;

   // Bit that ends the scan: MSB when normalizing left, LSB when normalizing right.
   assign test_bit = md ? sreg[0] : sreg[WIDTH-1];
   // A new operation may be accepted whenever we are not mid-scan.
   assign load     = start && (state != SHIFT);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic and status outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (operand == '0) ? DONE : SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (test_bit) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nxt = (operand == '0) ? DONE : SHIFT;
            else       state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture, one-bit-per-cycle shift, and result registers
   // that hold until the next completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         sreg   <= '0;
         cnt    <= '0;
         md     <= 1'b0;
         result <= '0;
         count  <= '0;
         zero   <= 1'b0;
      end else if (load) begin
         sreg <= operand;
         md   <= mode;
         cnt  <= '0;
         // All-zero operand never terminates a scan, so finish it right here.
         if (operand == '0) begin
            result <= '0;
            count  <= CW'(WIDTH);
            zero   <= 1'b1;
         end
      end else if (state == SHIFT) begin
         if (test_bit) begin
            result <= sreg;
            count  <= cnt;
            zero   <= 1'b0;
         end else begin
            sreg <= md ? (sreg >> 1) : (sreg << 1);
            cnt  <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_iter_normalizer.sv
// Directed bench for iter_normalizer: latency, result/count/zero, busy
// duration, start ignored during SHIFT, back-to-back load and mid-op reset.
module tb_iter_normalizer;
   logic        clk = 1'b0;
   logic        reset, start, mode;
   logic [31:0] operand;
   logic        busy, done, zero;
   logic [31:0] result;
   logic [5:0]  count;

   int tests = 0;
   int fails = 0;
   int edges, busyc;
   bit overlap = 1'b0;
   bit seen;

   iter_normalizer dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .operand(operand),
      .busy(busy), .done(done), .result(result), .count(count), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present an operation for one edge (the load edge); returns just after it.
   task automatic launch(input logic [31:0] op, input logic m);
      operand = op;
      mode    = m;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   // Wait for done, counting edges (starting from e0) and busy cycles.
   task automatic wait_done(input int e0, output int e, output int b);
      e = e0;
      b = 0;
      while (!done && e < 100) begin
         if (busy) b++;
         if (busy && done) overlap = 1'b1;
         @(posedge clk); #1;
         e++;
      end
      chk("done_seen", done, 1);
      if (busy && done) overlap = 1'b1;
   endtask

   task automatic op_check(input string tag, input logic [31:0] op, input logic m,
                           input int exp_e, input int exp_b, input logic [31:0] exp_r,
                           input logic [5:0] exp_c, input logic exp_z);
      launch(op, m);
      wait_done(1, edges, busyc);
      chk({tag, "_edges"}, edges, exp_e);
      chk({tag, "_busy"}, busyc, exp_b);
      chk({tag, "_result"}, result, exp_r);
      chk({tag, "_count"}, count, exp_c);
      chk({tag, "_zero"}, zero, exp_z);
      @(posedge clk); #1;
      chk({tag, "_done_1cyc"}, done, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mode = 1'b0; operand = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_count", count, 0);
      chk("rst_zero", zero, 0);

      op_check("msb_m0",  32'h8000_0000, 1'b0,  2,  1, 32'h8000_0000,  0, 1'b0);
      op_check("one_m0",  32'h0000_0001, 1'b0, 33, 32, 32'h8000_0000, 31, 1'b0);
      op_check("one_m1",  32'h0000_0001, 1'b1,  2,  1, 32'h0000_0001,  0, 1'b0);
      op_check("f0_m1",   32'h00F0_0000, 1'b1, 22, 21, 32'h0000_000F, 20, 1'b0);
      op_check("f0_m0",   32'h00F0_0000, 1'b0, 10,  9, 32'hF000_0000,  8, 1'b0);
      op_check("zero_m0", 32'h0000_0000, 1'b0,  1,  0, 32'h0000_0000, 32, 1'b1);
      op_check("zero_m1", 32'h0000_0000, 1'b1,  1,  0, 32'h0000_0000, 32, 1'b1);
      op_check("unzero",  32'h0000_0001, 1'b0, 33, 32, 32'h8000_0000, 31, 1'b0);

      // start pulsed mid-scan must be ignored
      launch(32'h0000_1000, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      operand = 32'hFFFF_FFFF; mode = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(5, edges, busyc);
      chk("ign_edges", edges, 21);
      chk("ign_count", count, 19);
      chk("ign_result", result, 32'h8000_0000);
      // back-to-back load during the DONE cycle
      launch(32'h4000_0000, 1'b0);
      wait_done(1, edges, busyc);
      chk("b2b_edges", edges, 3);
      chk("b2b_count", count, 1);
      chk("b2b_result", result, 32'h8000_0000);
      @(posedge clk); #1;

      // reset mid-scan aborts with no done pulse
      launch(32'h0000_0001, 1'b0);
      repeat (5) begin @(posedge clk); #1; end
      chk("mid_busy_before", busy, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid_busy", busy, 0);
      chk("mid_done", done, 0);
      chk("mid_count", count, 0);
      chk("mid_result", result, 0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1'b1;
      end
      chk("mid_no_done", seen, 0);

      chk("busy_done_excl", overlap, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
